// File: rtl/rastreador_min_max_pkg.sv
// rtl/rastreador_min_max_pkg.sv - shared types and constants for the running min/max tracker
package rastreador_min_max_pkg;

  localparam int DATA_W = 32;
  localparam int FRAC_W = 10;
  localparam logic [DATA_W-1:0] NEG_ZERO = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CMP_MIN = 2'd1,
    CMP_MAX = 2'd2,
    REPORT  = 2'd3
  } state_t;

  // Either zero encoding (+0 or -0) has an all-zero magnitude field.
  function automatic logic is_zero(input logic [DATA_W-1:0] x);
    return (x & ~NEG_ZERO) == '0;
  endfunction

endpackage

// File: rtl/rastreador_min_max_if.sv
// rtl/rastreador_min_max_if.sv - sample input stream and per-frame result stream
interface rastreador_min_max_if
  import rastreador_min_max_pkg::*;
#(
  parameter int CNT_W = 16
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_min;
  logic [DATA_W-1:0] res_max;
  logic [CNT_W-1:0]  res_count;

  modport master (
    output in_valid, in_data, in_last, res_ready,
    input  in_ready, res_valid, res_min, res_max, res_count
  );

  modport slave (
    input  in_valid, in_data, in_last, res_ready,
    output in_ready, res_valid, res_min, res_max, res_count
  );

endinterface

// File: rtl/rastreador_min_max_comparador.sv
// rtl/rastreador_min_max_comparador.sv - sign-magnitude Q21.10 comparator (a vs b), +0 equals -0
module rastreador_min_max_comparador
  import rastreador_min_max_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              lt,
  output logic              gt,
  output logic              eq
);

  logic [DATA_W-2:0] mag_a;
  logic [DATA_W-2:0] mag_b;
  logic              mag_lt;
  logic              mag_eq;

  always_comb begin
    // Integer field is the high part of the magnitude, so a plain unsigned compare orders it.
    mag_a  = {a[DATA_W-2:FRAC_W], a[FRAC_W-1:0]};
    mag_b  = {b[DATA_W-2:FRAC_W], b[FRAC_W-1:0]};
    mag_lt = mag_a < mag_b;
    mag_eq = mag_a == mag_b;
    eq     = (is_zero(a) && is_zero(b)) || ((a[DATA_W-1] == b[DATA_W-1]) && mag_eq);
    if (eq) begin
      lt = 1'b0;
    end else if (a[DATA_W-1] != b[DATA_W-1]) begin
      lt = a[DATA_W-1];
    end else if (a[DATA_W-1]) begin
      lt = !mag_lt;
    end else begin
      lt = mag_lt;
    end
    gt = !eq && !lt;
  end

endmodule

// File: rtl/rastreador_min_max.sv
// rtl/rastreador_min_max.sv - per-frame running min/max/count tracker sharing one comparator
module rastreador_min_max
  import rastreador_min_max_pkg::*;
#(
  parameter int CNT_W = 16
)(
  input  logic                clk,
  input  logic                rst_n,
  rastreador_min_max_if.slave bus
);

  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] smp;
  logic              lst;
  logic [DATA_W-1:0] min_q;
  logic [DATA_W-1:0] max_q;
  logic [CNT_W-1:0]  count;
  logic              first;

  logic              accept;
  logic [DATA_W-1:0] cmp_b;
  logic              cmp_lt;
  logic              cmp_gt;
  logic              cmp_eq;

  rastreador_min_max_comparador u_cmp (
    .a  (smp),
    .b  (cmp_b),
    .lt (cmp_lt),
    .gt (cmp_gt),
    .eq (cmp_eq)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (first) begin
            state_nxt = bus.in_last ? REPORT : IDLE;
          end else begin
            state_nxt = CMP_MIN;
          end
        end
      end
      CMP_MIN: state_nxt = CMP_MAX;
      CMP_MAX: state_nxt = lst ? REPORT : IDLE;
      REPORT:  state_nxt = bus.res_ready ? IDLE : REPORT;
      default: state_nxt = IDLE;
    endcase
  end

  // in_ready is also held low while reset is asserted, since state alone reads IDLE then.
  always_comb begin
    bus.in_ready  = rst_n && (state == IDLE);
    bus.res_valid = (state == REPORT);
    bus.res_min   = min_q;
    bus.res_max   = max_q;
    bus.res_count = count;
    cmp_b         = (state == CMP_MAX) ? max_q : min_q;
  end

  assign accept = bus.in_valid && (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp   <= '0;
      lst   <= 1'b0;
      min_q <= '0;
      max_q <= '0;
      count <= '0;
      first <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            smp <= bus.in_data;
            lst <= bus.in_last;
            if (count != '1) begin
              count <= count + 1'b1;
            end
            if (first) begin
              min_q <= bus.in_data;
              max_q <= bus.in_data;
              first <= 1'b0;
            end
          end
        end
        CMP_MIN: begin
          if (cmp_lt) begin
            min_q <= smp;
          end
        end
        CMP_MAX: begin
          if (cmp_gt) begin
            max_q <= smp;
          end
        end
        REPORT: begin
          if (bus.res_ready) begin
            count <= '0;
            first <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rastreador_min_max.sv
// tb/tb_rastreador_min_max.sv - randomized and directed self-checking bench for rastreador_min_max
module tb_rastreador_min_max;
  import rastreador_min_max_pkg::*;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rastreador_min_max_if #(.CNT_W(CNT_W)) bus ();

  rastreador_min_max #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_min;
  logic [31:0] exp_max;
  int          exp_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic longint sm_val(input logic [31:0] x);
    longint m;
    m = longint'(x[30:0]);
    return x[31] ? -m : m;
  endfunction

  // Strict comparisons keep the earliest of equal values.
  task automatic model(input logic [31:0] s[$]);
    exp_min = s[0];
    exp_max = s[0];
    for (int i = 1; i < s.size(); i++) begin
      if (sm_val(s[i]) < sm_val(exp_min)) exp_min = s[i];
      if (sm_val(s[i]) > sm_val(exp_max)) exp_max = s[i];
    end
    exp_cnt = (s.size() > CNT_MAX) ? CNT_MAX : s.size();
  endtask

  task automatic send_sample(input logic [31:0] d, input logic last, output int waits);
    waits = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    while (!bus.in_ready && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    if (waits >= 20) chk("ready_timeout", {31'b0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] s[$]);
    int w;
    for (int i = 0; i < s.size(); i++) begin
      send_sample(s[i], i == s.size() - 1, w);
      if (i >= 2) chk("ready_gap", w, 32'd2);
      else if (i == 1) chk("ready_after_first", w, 32'd0);
    end
  endtask

  task automatic get_result(input int hold);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.res_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("res_valid_rise", {31'b0, bus.res_valid}, 32'd1);
    for (int h = 0; h < hold; h++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = $urandom;
      bus.in_last  = 1'b1;
      chk("hold_valid", {31'b0, bus.res_valid}, 32'd1);
      chk("hold_ready", {31'b0, bus.in_ready}, 32'd0);
      chk("hold_min", bus.res_min, exp_min);
      chk("hold_max", bus.res_max, exp_max);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    chk("res_min", bus.res_min, exp_min);
    chk("res_max", bus.res_max, exp_max);
    chk("res_count", {{(32-CNT_W){1'b0}}, bus.res_count}, exp_cnt);
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.res_ready = 1'b0;
    chk("post_valid", {31'b0, bus.res_valid}, 32'd0);
    chk("post_ready", {31'b0, bus.in_ready}, 32'd1);
    chk("post_count", {{(32-CNT_W){1'b0}}, bus.res_count}, 32'd0);
    chk("post_min_kept", bus.res_min, exp_min);
  endtask

  function automatic logic [31:0] rnd_sample();
    logic [31:0] pool [4];
    pool[0] = 32'h0000_0000;
    pool[1] = 32'h8000_0000;
    pool[2] = 32'h0000_0400;
    pool[3] = 32'h8000_0400;
    if ($urandom_range(3) == 0) return pool[$urandom_range(3)];
    return $urandom;
  endfunction

  task automatic run_frame(input logic [31:0] s[$], input int hold);
    model(s);
    send_frame(s);
    get_result(hold);
  endtask

  logic [31:0] q[$];
  int          w;

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'hDEAD_BEEF;
    bus.in_last   = 1'b1;
    bus.res_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_res_valid", {31'b0, bus.res_valid}, 32'd0);
    chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd0);
    chk("rst_min", bus.res_min, 32'd0);
    chk("rst_max", bus.res_max, 32'd0);
    chk("rst_count", {{(32-CNT_W){1'b0}}, bus.res_count}, 32'd0);
    bus.in_valid = 1'b0;
    rst_n        = 1'b1;
    #1;
    chk("rel_in_ready", {31'b0, bus.in_ready}, 32'd1);

    q = '{32'h0000_0400, 32'h8000_0400, 32'h0000_0200, 32'h0098_9680};
    run_frame(q, 0);
    q = '{32'h8000_0000, 32'h0000_0000};
    run_frame(q, 0);
    q = '{32'hA8D9_9763, 32'hDE6D_23E4};
    run_frame(q, 0);
    q = '{32'hB2EF_5901};
    run_frame(q, 5);
    q = '{32'h0000_0001, 32'h8000_0001};
    run_frame(q, 0);

    for (int f = 0; f < 25; f++) begin
      q = {};
      for (int i = 0; i < $urandom_range(6, 1); i++) q.push_back(rnd_sample());
      run_frame(q, $urandom_range(2));
    end

    q = {};
    for (int i = 0; i < 20; i++) q.push_back(rnd_sample());
    run_frame(q, 0);

    send_sample(32'h1234_5678, 1'b0, w);
    send_sample(32'h8765_4321, 1'b0, w);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", {31'b0, bus.res_valid}, 32'd0);
    chk("midrst_ready", {31'b0, bus.in_ready}, 32'd0);
    chk("midrst_min", bus.res_min, 32'd0);
    chk("midrst_max", bus.res_max, 32'd0);
    chk("midrst_count", {{(32-CNT_W){1'b0}}, bus.res_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    q = '{32'h14C7_DBC7};
    run_frame(q, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
